// File: rtl/axis_bist_multi.sv
// rtl/axis_bist_multi.sv - multi-channel AXI-Stream BIST generator/checker
module axis_bist_multi #(
  parameter int WIDTH     = 64,
  parameter int NCHAN     = 2,
  parameter int SR_AWIDTH = 8,
  parameter int SR_BASE   = 0
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst_n,
  input  logic                   set_stb,
  input  logic [SR_AWIDTH-1:0]   set_addr,
  input  logic [31:0]            set_data,
  output logic [31:0]            rb_data,
  output logic [NCHAN*WIDTH-1:0] m_tdata,
  output logic [NCHAN-1:0]       m_tlast,
  output logic [NCHAN-1:0]       m_tvalid,
  input  logic [NCHAN-1:0]       m_tready,
  input  logic [NCHAN*WIDTH-1:0] s_tdata,
  input  logic [NCHAN-1:0]       s_tlast,
  input  logic [NCHAN-1:0]       s_tvalid,
  output logic [NCHAN-1:0]       s_tready,
  output logic                   running,
  output logic                   done,
  output logic [NCHAN-1:0]       error
);

  localparam int BYTES = WIDTH / 8;
  localparam int LANES = WIDTH / 32;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [SR_AWIDTH-1:0] A_CTRL  = SR_AWIDTH'(SR_BASE + 0);
  localparam logic [SR_AWIDTH-1:0] A_CFG   = SR_AWIDTH'(SR_BASE + 1);
  localparam logic [SR_AWIDTH-1:0] A_THR   = SR_AWIDTH'(SR_BASE + 2);
  localparam logic [SR_AWIDTH-1:0] A_SEED  = SR_AWIDTH'(SR_BASE + 3);
  localparam logic [SR_AWIDTH-1:0] A_RBSEL = SR_AWIDTH'(SR_BASE + 4);

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DRAIN, T_DONE} top_t;
  typedef enum logic [1:0] {G_IDLE, G_SEND, G_GAP, G_STOP} gen_t;

  // Galois LFSR x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  logic             go_r, cont_r, len_ramp_r;
  logic [1:0]       pat_r;
  logic [NCHAN-1:0] en_r;
  logic [17:0]      num_pkts_r;
  logic [12:0]      pkt_len_r;
  logic [15:0]      thr_r;
  logic [31:0]      seed_r;
  logic [2:0]       rb_sel_r;

  logic unused_set;
  assign unused_set = ^set_data;

  top_t top_state, top_next;
  logic go_rise;
  logic [NCHAN-1:0] data_err, len_err, d_err_now, l_err_now, gen_stop;
  logic any_err, all_stopped, counts_match;
  logic [31:0] tx_cnt [NCHAN];
  logic [31:0] rx_cnt [NCHAN];
  logic [13:0] rx_idx [NCHAN];
  logic [31:0] xfer_cnt, cyc_cnt, len_full;
  logic [13:0] len_words;
  logic [7:0]  fail_chan, ff_chan;
  logic [13:0] fail_idx, ff_idx;

  // A go rising edge is taken straight from the CTRL write so RUN begins the next cycle
  assign go_rise = set_stb && (set_addr == A_CTRL) && set_data[0] && !go_r &&
                   (top_state == T_IDLE || top_state == T_DONE);

  assign any_err     = |(data_err | len_err);
  assign error       = data_err | len_err;
  assign all_stopped = &gen_stop;
  assign s_tready    = '1;

  // Settings register file
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      go_r <= 1'b0; cont_r <= 1'b0; pat_r <= '0; en_r <= '0;
      num_pkts_r <= '0; pkt_len_r <= '0; len_ramp_r <= 1'b0;
      thr_r <= '0; seed_r <= '0; rb_sel_r <= '0;
    end else if (set_stb) begin
      if (set_addr == A_CTRL) begin
        go_r   <= set_data[0];
        cont_r <= set_data[1];
        pat_r  <= set_data[3:2];
        en_r   <= set_data[8 +: NCHAN];
      end
      if (set_addr == A_CFG) begin
        num_pkts_r <= set_data[17:0];
        pkt_len_r  <= set_data[30:18];
        len_ramp_r <= set_data[31];
      end
      if (set_addr == A_THR)   thr_r    <= set_data[15:0];
      if (set_addr == A_SEED)  seed_r   <= set_data;
      if (set_addr == A_RBSEL) rb_sel_r <= set_data[2:0];
    end
  end

  // Words per packet, never less than one
  always_comb begin
    len_full  = (32'(pkt_len_r) + 32'(BYTES - 1)) / 32'(BYTES);
    len_words = (len_full == 32'd0) ? 14'd1 : 14'(len_full);
  end

  // Drain is complete when every enabled channel has received what it sent
  always_comb begin
    counts_match = 1'b1;
    for (int i = 0; i < NCHAN; i++)
      if (en_r[i] && (tx_cnt[i] != rx_cnt[i])) counts_match = 1'b0;
  end

  // Top-level test sequencing
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) top_state <= T_IDLE;
    else            top_state <= top_next;
  end

  // Top-level next state
  always_comb begin
    top_next = top_state;
    case (top_state)
      T_IDLE:  if (go_rise) top_next = T_RUN;
      T_RUN:   if (all_stopped) top_next = T_DRAIN;
      T_DRAIN: if (any_err || counts_match) top_next = T_DONE;
      T_DONE: begin
        if (go_rise)    top_next = T_RUN;
        else if (!go_r) top_next = T_IDLE;
      end
      default: top_next = T_IDLE;
    endcase
  end

  // Status flags; done holds through IDLE until the next go edge
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      running <= (top_next == T_RUN) || (top_next == T_DRAIN);
      if (go_rise)                  done <= 1'b0;
      else if (top_next == T_DONE)  done <= 1'b1;
    end
  end

  // Saturating throughput counters
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      xfer_cnt <= '0;
      cyc_cnt  <= '0;
    end else if (go_rise) begin
      xfer_cnt <= '0;
      cyc_cnt  <= '0;
    end else begin
      if (|(m_tvalid & m_tready) && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 32'd1;
      if (running && cyc_cnt != '1)                 cyc_cnt  <= cyc_cnt + 32'd1;
    end
  end

  // Sticky error flags, cleared when a new run starts
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      data_err <= '0;
      len_err  <= '0;
    end else if (go_rise) begin
      data_err <= '0;
      len_err  <= '0;
    end else begin
      data_err <= data_err | d_err_now;
      len_err  <= len_err  | l_err_now;
    end
  end

  // Lowest-numbered channel failing this cycle, with its word index
  always_comb begin
    ff_chan = '0;
    ff_idx  = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (d_err_now[i] || l_err_now[i]) begin
        ff_chan = 8'(i);
        ff_idx  = rx_idx[i];
      end
  end

  // Record only the first failure of the run
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      fail_chan <= '0;
      fail_idx  <= '0;
    end else if (go_rise) begin
      fail_chan <= '0;
      fail_idx  <= '0;
    end else if (!any_err && |(d_err_now | l_err_now)) begin
      fail_chan <= ff_chan;
      fail_idx  <= ff_idx;
    end
  end

  // Readback mux
  always_comb begin
    rb_data = '0;
    case (rb_sel_r)
      3'd0: begin
        rb_data[8 +: NCHAN] = error;
        rb_data[3] = |len_err;
        rb_data[2] = |data_err;
        rb_data[1] = done;
        rb_data[0] = running;
      end
      3'd1:    rb_data = xfer_cnt;
      3'd2:    rb_data = cyc_cnt;
      3'd3:    rb_data = {fail_chan, 10'd0, fail_idx};
      default: rb_data = '0;
    endcase
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    gen_t        g_state, g_next;
    logic [13:0] g_idx, g_len, g_rlen, g_rlen_inc, g_rlen_now, g_new_len;
    logic [15:0] g_gap;
    logic [31:0] g_lfsr, g_cnt, g_sent, g_lane, seed_c;
    logic        g_hs, g_last, g_stop, g_start;

    logic [13:0] r_idx, r_rlen, r_len;
    logic [31:0] r_lfsr, r_cnt, r_lane;
    logic        r_check;

    assign seed_c     = seed_r ^ 32'(c);
    assign g_hs       = m_tvalid[c] & m_tready[c];
    assign g_last     = (g_idx == g_len - 14'd1);
    assign g_rlen_inc = (g_rlen >= len_words) ? 14'd1 : g_rlen + 14'd1;
    assign g_rlen_now = (g_hs && g_last) ? g_rlen_inc : g_rlen;
    assign g_sent     = (g_hs && g_last) ? g_cnt + 32'd1 : g_cnt;
    assign g_new_len  = len_ramp_r ? g_rlen_now : len_words;
    assign g_stop     = !en_r[c] || !go_r ||
                        (!cont_r && g_sent >= 32'(num_pkts_r)) || (cont_r && any_err);
    assign g_start    = (g_next == G_SEND) && (g_state != G_SEND || (g_hs && g_last));

    assign m_tvalid[c] = (g_state == G_SEND);
    assign m_tlast[c]  = (g_state == G_SEND) && g_last;
    assign m_tdata[c*WIDTH +: WIDTH] = {LANES{g_lane}};
    assign gen_stop[c] = (g_state == G_STOP);
    assign tx_cnt[c]   = g_cnt;
    assign rx_cnt[c]   = r_cnt;
    assign rx_idx[c]   = r_idx;

    // Generator lane pattern
    always_comb begin
      case (pat_r)
        2'd0:    g_lane = seed_r;
        2'd2:    g_lane = g_lfsr;
        default: g_lane = seed_r + 32'(g_idx);
      endcase
    end

    // Generator state register; a new run restarts from IDLE
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n)   g_state <= G_IDLE;
      else if (go_rise) g_state <= G_IDLE;
      else              g_state <= g_next;
    end

    // Generator next state; stop is only decided on packet boundaries
    always_comb begin
      g_next = g_state;
      case (g_state)
        G_IDLE: if (top_state == T_RUN) g_next = g_stop ? G_STOP : G_SEND;
        G_SEND: if (g_hs && g_last) begin
          if (thr_r != 16'd0) g_next = G_GAP;
          else                g_next = g_stop ? G_STOP : G_SEND;
        end
        G_GAP:  if (g_gap <= 16'd1) g_next = g_stop ? G_STOP : G_SEND;
        default: g_next = g_state;
      endcase
    end

    // Generator datapath: word index, packet length, LFSR, gap timer, packet count
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
        g_idx <= '0; g_len <= '0; g_rlen <= '0; g_gap <= '0; g_lfsr <= '0; g_cnt <= '0;
      end else if (go_rise) begin
        g_idx  <= '0;
        g_len  <= 14'd1;
        g_rlen <= 14'd1;
        g_gap  <= '0;
        g_lfsr <= (seed_c == 32'd0) ? 32'd1 : seed_c;
        g_cnt  <= '0;
      end else begin
        if (g_hs) begin
          g_idx  <= g_last ? 14'd0 : g_idx + 14'd1;
          g_lfsr <= lfsr_step(g_lfsr);
        end
        if (g_hs && g_last) begin
          g_cnt  <= g_cnt + 32'd1;
          g_rlen <= g_rlen_inc;
        end
        if (g_start) g_len <= g_new_len;
        if (g_state == G_SEND && g_next == G_GAP) g_gap <= thr_r;
        else if (g_state == G_GAP)                g_gap <= g_gap - 16'd1;
      end
    end

    assign r_check = s_tvalid[c] && s_tready[c] && en_r[c] &&
                     (top_state == T_RUN || top_state == T_DRAIN);
    assign r_len   = len_ramp_r ? r_rlen : len_words;

    // Checker reference lane
    always_comb begin
      case (pat_r)
        2'd0:    r_lane = seed_r;
        2'd2:    r_lane = r_lfsr;
        default: r_lane = seed_r + 32'(r_idx);
      endcase
    end

    assign d_err_now[c] = r_check && (s_tdata[c*WIDTH +: WIDTH] != {LANES{r_lane}});
    assign l_err_now[c] = r_check && (s_tlast[c] != (r_idx == r_len - 14'd1));

    // Checker tracks packet boundaries by the returning tlast
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
        r_idx <= '0; r_rlen <= '0; r_lfsr <= '0; r_cnt <= '0;
      end else if (go_rise) begin
        r_idx  <= '0;
        r_rlen <= 14'd1;
        r_lfsr <= (seed_c == 32'd0) ? 32'd1 : seed_c;
        r_cnt  <= '0;
      end else if (r_check) begin
        r_lfsr <= lfsr_step(r_lfsr);
        if (s_tlast[c]) begin
          r_idx  <= '0;
          r_cnt  <= r_cnt + 32'd1;
          r_rlen <= (r_rlen >= len_words) ? 14'd1 : r_rlen + 14'd1;
        end else begin
          r_idx <= r_idx + 14'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_bist_multi.sv
// tb/tb_axis_bist_multi.sv - randomized loopback bench for axis_bist_multi
module tb_axis_bist_multi;
  localparam int W = 64;
  localparam int N = 2;

  logic           bus_clk = 1'b0;
  logic           bus_rst_n = 1'b0;
  logic           set_stb = 1'b0;
  logic [7:0]     set_addr = '0;
  logic [31:0]    set_data = '0;
  logic [31:0]    rb_data;
  logic [N*W-1:0] m_tdata, s_tdata;
  logic [N-1:0]   m_tlast, m_tvalid, s_tlast, s_tvalid, s_tready, error;
  logic [N-1:0]   m_tready = '0;
  logic           running, done;
  logic           flip0 = 1'b0, flip1 = 1'b0, rdy_rand = 1'b0;

  int total = 0, bad = 0;

  logic         model_on = 1'b0;
  int           cfg_pat, cfg_len;
  bit           cfg_ramp;
  logic [31:0]  cfg_seed, ctrl_word;
  logic [N-1:0] cfg_mask;
  int unsigned  mdl_pkt [N], mdl_beat [N], rx_pkts [N];
  logic [31:0]  mdl_lfsr [N];
  int unsigned  xfer_seen;
  logic [63:0]  first_d0;

  axis_bist_multi #(.WIDTH(W), .NCHAN(N), .SR_AWIDTH(8), .SR_BASE(0)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_data(rb_data),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .running(running), .done(done), .error(error)
  );

  always #5 bus_clk = ~bus_clk;

  assign s_tdata  = m_tdata ^ {flip1, 63'd0, flip0, 63'd0};
  assign s_tvalid = m_tvalid & m_tready;
  assign s_tlast  = m_tlast;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic int unsigned pkt_words(input int unsigned n);
    return cfg_ramp ? (n % cfg_len) + 1 : cfg_len;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge bus_clk); #1;
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge bus_clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic rb_read(input logic [2:0] sel, output logic [31:0] v);
    sr_write(8'd4, 32'(sel));
    @(negedge bus_clk);
    v = rb_data;
  endtask

  task automatic start_test(input int pat, input bit cont, input logic [1:0] mask,
                            input logic [31:0] seed, input int num, input int lenb,
                            input bit ramp, input int thr);
    sr_write(8'd1, {ramp, 13'(lenb), 18'(num)});
    sr_write(8'd2, 32'(thr));
    sr_write(8'd3, seed);
    cfg_pat = pat; cfg_seed = seed; cfg_ramp = ramp; cfg_mask = mask;
    cfg_len = (lenb + 7) / 8;
    if (cfg_len == 0) cfg_len = 1;
    for (int c = 0; c < N; c++) begin
      mdl_pkt[c] = 0; mdl_beat[c] = 0; rx_pkts[c] = 0;
      mdl_lfsr[c] = seed ^ 32'(c);
      if (mdl_lfsr[c] == 32'd0) mdl_lfsr[c] = 32'd1;
    end
    xfer_seen = 0;
    model_on = 1'b1;
    ctrl_word = {16'd0, 6'd0, mask, 4'd0, 2'(pat), cont, 1'b1};
    sr_write(8'd0, ctrl_word);
  endtask

  task automatic stop_go();
    sr_write(8'd0, ctrl_word & ~32'd1);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge bus_clk);
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // Ready pattern for the generator side
  initial begin
    forever begin
      @(posedge bus_clk); #1;
      m_tready = rdy_rand ? 2'($urandom) : 2'b11;
    end
  end

  // Scoreboard: every accepted generator beat against the spec-level stream
  always @(negedge bus_clk) begin
    if (model_on) begin
      logic hit;
      logic [31:0] lane;
      int unsigned words;
      hit = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (!cfg_mask[c]) chk($sformatf("ch%0d_disabled_valid", c), m_tvalid[c], 1'b0);
        if (m_tvalid[c] && m_tready[c]) begin
          hit = 1'b1;
          case (cfg_pat)
            0:       lane = cfg_seed;
            2:       lane = mdl_lfsr[c];
            default: lane = cfg_seed + mdl_beat[c];
          endcase
          words = pkt_words(mdl_pkt[c]);
          if (c == 0 && mdl_pkt[0] == 0 && mdl_beat[0] == 0) first_d0 = m_tdata[63:0];
          chk($sformatf("ch%0d_data", c), m_tdata[c*W +: W], {lane, lane});
          chk($sformatf("ch%0d_tlast", c), m_tlast[c], mdl_beat[c] == words - 1);
          mdl_lfsr[c] = lfsr_next(mdl_lfsr[c]);
          if (mdl_beat[c] == words - 1) begin
            mdl_beat[c] = 0;
            mdl_pkt[c]++;
          end else begin
            mdl_beat[c]++;
          end
        end
        if (s_tvalid[c] && s_tready[c] && s_tlast[c]) rx_pkts[c]++;
      end
      if (hit) xfer_seen++;
    end
  end

  initial begin
    logic [31:0] v, x, y;
    int n;

    chk("pin_lfsr_1", lfsr_next(32'd1), 32'h8020_0003);
    chk("pin_lfsr_2", lfsr_next(32'd2), 32'd1);

    repeat (3) @(posedge bus_clk);
    #1 bus_rst_n = 1'b1;
    @(negedge bus_clk);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 2'b00);
    chk("rst_m_tvalid", m_tvalid, 2'b00);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_s_tready", s_tready, 2'b11);
    chk("rst_rb", rb_data, 32'd0);

    // Const pattern, 10 packets of 40 bytes on both channels
    rdy_rand = 1'b1;
    start_test(0, 1'b0, 2'b11, 32'h0123_4567, 10, 40, 1'b0, 0);
    chk("pin_len_40b", cfg_len, 5);
    wait_done("const_done", 2000);
    model_on = 1'b0;
    chk("const_error", error, 2'b00);
    chk("const_first_beat", first_d0, 64'h0123_4567_0123_4567);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("const_tx%0d", c), mdl_pkt[c], 10);
      chk($sformatf("const_rx%0d", c), rx_pkts[c], 10);
    end
    rb_read(3'd0, v);
    chk("const_rb_status", v[3:0], 4'b0010);
    rb_read(3'd1, v);
    chk("const_xfer_cnt", v, xfer_seen);
    stop_go();

    // PRBS with channel 1 bit 63 flipped on the return path
    rdy_rand = 1'b0;
    flip1 = 1'b1;
    start_test(2, 1'b0, 2'b11, $urandom, 5, 40, 1'b0, 0);
    wait_done("flip_done", 2000);
    model_on = 1'b0;
    flip1 = 1'b0;
    chk("flip_error", error, 2'b10);
    rb_read(3'd0, v);
    chk("flip_rb_errbits", v[3:2], 2'b01);
    chk("flip_rb_chanerr", v[9:8], 2'b10);
    rb_read(3'd3, v);
    chk("flip_first_fail", v, 32'h0100_0000);
    stop_go();

    // Ramped lengths under random backpressure
    rdy_rand = 1'b1;
    start_test(int'($urandom_range(0, 3)), 1'b0, 2'b11, $urandom, 1000, 40, 1'b1, 0);
    wait_done("ramp_done", 20000);
    model_on = 1'b0;
    chk("ramp_error", error, 2'b00);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("ramp_tx%0d", c), mdl_pkt[c], 1000);
      chk($sformatf("ramp_rx%0d", c), rx_pkts[c], 1000);
    end
    stop_go();

    // Continuous PRBS stopped by clearing go
    start_test(2, 1'b1, 2'b11, $urandom, 0, 40, 1'b0, int'($urandom_range(0, 3)));
    repeat (200) @(posedge bus_clk);
    stop_go();
    wait_done("cont_stop_done", 2000);
    model_on = 1'b0;
    chk("cont_stop_error", error, 2'b00);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("cont_stop_rx_eq_tx%0d", c), rx_pkts[c], mdl_pkt[c]);
      chk($sformatf("cont_stop_whole_pkt%0d", c), mdl_beat[c], 0);
      chk($sformatf("cont_stop_sent%0d", c), mdl_pkt[c] > 0, 1'b1);
    end

    // Continuous PRBS stopped by an injected error on channel 0
    rdy_rand = 1'b0;
    start_test(2, 1'b1, 2'b11, $urandom, 0, 40, 1'b0, 0);
    repeat (1000) @(posedge bus_clk);
    #1 flip0 = 1'b1;
    n = 0;
    do begin
      @(negedge bus_clk);
      n++;
    end while (!(m_tvalid[0] && m_tready[0]) && n < 100);
    @(posedge bus_clk); #1 flip0 = 1'b0;
    wait_done("cont_err_done", 2000);
    chk("cont_err_error", error, 2'b01);
    n = 0;
    repeat (20) begin
      @(negedge bus_clk);
      if (m_tvalid != 2'b00) n++;
    end
    chk("cont_err_gen_quiet", n, 0);
    model_on = 1'b0;
    for (int c = 0; c < N; c++)
      chk($sformatf("cont_err_whole_pkt%0d", c), mdl_beat[c], 0);
    stop_go();

    // Throughput with no throttle, then with a long throttle
    start_test(0, 1'b0, 2'b01, $urandom, 10, 8000, 1'b0, 0);
    wait_done("tput0_done", 15000);
    model_on = 1'b0;
    rb_read(3'd1, x);
    rb_read(3'd2, y);
    chk("tput0_xfer", x, 10000);
    chk("tput0_ratio_gt80", (longint'(x) * 100 / longint'(y)) > 80, 1'b1);
    stop_go();

    start_test(0, 1'b0, 2'b01, $urandom, 10, 8000, 1'b0, 1000);
    wait_done("tput1k_done", 30000);
    model_on = 1'b0;
    rb_read(3'd1, x);
    rb_read(3'd2, y);
    chk("tput1k_xfer", x, 10000);
    chk("tput1k_ratio_lt50", (longint'(x) * 100 / longint'(y)) < 50, 1'b1);
    chk("tput1k_error", error, 2'b00);
    stop_go();

    // Asynchronous reset in the middle of a run
    start_test(1, 1'b0, 2'b11, $urandom, 100, 40, 1'b0, 0);
    repeat (30) @(posedge bus_clk);
    model_on = 1'b0;
    #1 bus_rst_n = 1'b0;
    #1;
    chk("arst_running", running, 1'b0);
    chk("arst_m_tvalid", m_tvalid, 2'b00);
    chk("arst_rb", rb_data, 32'd0);
    @(posedge bus_clk); #1 bus_rst_n = 1'b1;
    @(negedge bus_clk);
    chk("arst_after_done", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
